// File: rtl/hwpe_stream_sel_sequencer.sv
// Drives the select of a 2:1 static stream mux: LEN0 beats from source 0, then LEN1
// from source 1, re-emitting every beat through a 2-entry registered skid buffer.
module hwpe_stream_sel_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    len0_i,
    input  logic [CNT_WIDTH-1:0]    len1_i,
    output logic                    sel_o,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    push_valid_i,
    output logic                    push_ready_o,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic [DATA_WIDTH/8-1:0] push_strb_i,
    output logic                    pop_valid_o,
    input  logic                    pop_ready_i,
    output logic [DATA_WIDTH-1:0]   pop_data_o,
    output logic [DATA_WIDTH/8-1:0] pop_strb_o
);

    typedef enum logic [1:0] {IDLE, SRC0, SRC1, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    len0_q, len1_q, cnt_q, cnt_d;
    logic [1:0]              occ_q, occ_d;
    logic [DATA_WIDTH-1:0]   data_q [2];
    logic [DATA_WIDTH/8-1:0] strb_q [2];
    logic                    wr_q, rd_q;
    logic                    ready_q, sel_q, done_q;
    logic                    push_hs, pop_hs;

    assign push_hs = push_valid_i & ready_q;
    assign pop_hs  = (occ_q != 2'd0) & pop_ready_i;
    assign occ_d   = occ_q + 2'(push_hs) - 2'(pop_hs);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    if (len0_i != '0)      state_d = SRC0;
                    else if (len1_i != '0) state_d = SRC1;
                    else                   state_d = DRAIN;
                end
            end
            SRC0: begin
                if (push_hs) begin
                    if (cnt_q == len0_q - CNT_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = (len1_q != '0) ? SRC1 : DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            SRC1: begin
                if (push_hs) begin
                    if (cnt_q == len1_q - CNT_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (done_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != IDLE);
        sel_o        = sel_q;
        done_o       = done_q;
        push_ready_o = ready_q;
        pop_valid_o  = (occ_q != 2'd0);
    end

    // ready/sel are computed from the next state and occupancy, so both switch on
    // the very edge that takes the last beat of a phase and never mid-transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            len0_q  <= '0;
            len1_q  <= '0;
            cnt_q   <= '0;
            occ_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            ready_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                len0_q <= len0_i;
                len1_q <= len1_i;
            end
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            ready_q <= (state_d == SRC0 || state_d == SRC1) && (occ_d != 2'd2);
            sel_q   <= (state_d == SRC1);
            done_q  <= (state_q == DRAIN) && (occ_q == 2'd0) && !done_q;
            if (push_hs) wr_q <= ~wr_q;
            if (pop_hs)  rd_q <= ~rd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_hs) begin
            data_q[wr_q] <= push_data_i;
            strb_q[wr_q] <= push_strb_i;
        end
    end

    assign pop_data_o = data_q[rd_q];
    assign pop_strb_o = strb_q[rd_q];

endmodule

// File: tb/tb_hwpe_stream_sel_sequencer.sv
// Randomized bench: two modelled sources behind a bench-side mux, checked every cycle
// against a beat-count / occupancy model of the sequencer.
module tb_hwpe_stream_sel_sequencer;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst, clear, start;
    logic [CW-1:0] len0, len1;
    logic          sel, busy, done;
    logic          push_valid, push_ready, pop_valid, pop_ready;
    logic [DW-1:0] push_data, pop_data;
    logic [DW/8-1:0] push_strb, pop_strb;

    always #5 clk = ~clk;

    hwpe_stream_sel_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .len0_i(len0), .len1_i(len1), .sel_o(sel), .busy_o(busy), .done_o(done),
        .push_valid_i(push_valid), .push_ready_o(push_ready),
        .push_data_i(push_data), .push_strb_i(push_strb),
        .pop_valid_o(pop_valid), .pop_ready_i(pop_ready),
        .pop_data_o(pop_data), .pop_strb_o(pop_strb)
    );

    // model: sequence active, beats accepted, beats buffered, expected pop order
    bit   m_active, m_done;
    int   m_acc, m_total, m_len0, m_occ;
    logic [35:0] ref_q[$];

    logic [35:0] sdata[2][NB];
    int   sidx[2];
    bit   sv[2];
    int   hs_src[2];

    int   pv, pr, hold;
    bit   start_req, clear_req, spurious;
    logic [CW-1:0] req_len0, req_len1;
    int   n_chk, n_pass, cyc, start_cyc, done_cyc, lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [35:0] src_word(input int s);
        if (sidx[s] < NB) return sdata[s][sidx[s]];
        return '0;
    endfunction

    task automatic cycle();
        bit ph, oh;
        logic [35:0] w;
        @(negedge clk);
        cyc++;
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("sel", sel, m_active && m_acc >= m_len0 && m_acc < m_total);
        chk("push_ready", push_ready, m_active && m_acc < m_total && m_occ < 2);
        chk("pop_valid", pop_valid, m_occ > 0);
        if (pop_valid && ref_q.size() > 0) chk("pop_beat", {pop_strb, pop_data}, ref_q[0]);
        if (done) done_cyc = cyc;
        for (int s = 0; s < 2; s++)
            if (!sv[s] && sidx[s] < NB) sv[s] = ($urandom_range(99) < pv);
        push_valid = sel ? sv[1] : sv[0];
        w = sel ? src_word(1) : src_word(0);
        {push_strb, push_data} = w;
        pop_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) < pr);
        if (hold > 0) hold--;
        clear = clear_req;
        clear_req = 1'b0;
        start = start_req || (spurious && m_active && $urandom_range(1) == 1);
        len0 = start_req ? req_len0 : CW'($urandom);
        len1 = start_req ? req_len1 : CW'($urandom);
        if (start_req) start_cyc = cyc;
        start_req = 1'b0;
        ph = push_valid && push_ready;
        oh = pop_valid && pop_ready;
        if (rst || clear) begin
            m_active = 0; m_done = 0; m_acc = 0; m_total = 0; m_len0 = 0; m_occ = 0;
            ref_q.delete();
        end else begin
            if (ph) begin
                sidx[int'(sel)]++;
                sv[int'(sel)] = 1'b0;
                hs_src[int'(sel)]++;
            end
            if (oh && ref_q.size() > 0) void'(ref_q.pop_front());
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_acc = 0; m_len0 = int'(len0);
                    m_total = int'(len0) + int'(len1);
                    for (int i = 0; i < int'(len0); i++) ref_q.push_back(sdata[0][sidx[0] + i]);
                    for (int i = 0; i < int'(len1); i++) ref_q.push_back(sdata[1][sidx[1] + i]);
                end
            end else if (m_done) begin
                m_active = 0; m_done = 0;
            end else begin
                if (m_acc == m_total && m_occ == 0) m_done = 1;
                m_acc += int'(ph);
            end
            m_occ += int'(ph) - int'(oh);
        end
    endtask

    task automatic init_src();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NB; i++) sdata[s][i] = {4'($urandom), 32'($urandom)};
            sidx[s] = 0; sv[s] = 1'b0; hs_src[s] = 0;
        end
    endtask

    task automatic run_seq(input int l0, input int l1, input int maxc,
                           input int hold_at, output int latency);
        init_src();
        req_len0 = CW'(l0);
        req_len1 = CW'(l1);
        start_req = 1'b1;
        done_cyc = -1;
        cycle();
        for (int i = 1; i <= maxc && done_cyc < 0; i++) begin
            if (i == hold_at) hold = 5;
            cycle();
        end
        cycle();
        chk("done_seen", done_cyc >= 0, 1'b1);
        chk("src0_beats", hs_src[0], l0);
        chk("src1_beats", hs_src[1], l1);
        chk("ref_empty", ref_q.size(), 0);
        latency = done_cyc - start_cyc;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; len0 = '0; len1 = '0;
        push_valid = 1'b0; push_data = '0; push_strb = '0; pop_ready = 1'b0;
        pv = 100; pr = 100; hold = 0; spurious = 1'b0;
        init_src();
        repeat (2) @(posedge clk);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // T1
        run_seq(3, 2, 50, -1, lat);
        chk("t1_latency", lat, 8);
        // T2
        run_seq(0, 4, 50, -1, lat);
        chk("t2_latency", lat, 7);
        // T3
        run_seq(0, 0, 20, -1, lat);
        chk("t3_latency", lat, 2);
        // T4: consumer stalls 5 cycles while source 0 keeps pushing
        run_seq(4, 4, 60, 3, lat);
        chk("t4_latency", lat, 16);
        // T5 plus a few random lengths with spurious starts while busy
        pv = 60; pr = 60; spurious = 1'b1;
        run_seq(7, 5, 1000, -1, lat);
        for (int k = 0; k < 4; k++) run_seq($urandom_range(6), $urandom_range(6), 1000, -1, lat);
        spurious = 1'b0;
        // T6: clear mid-SRC1 with one beat buffered, then restart
        pv = 100; pr = 100;
        init_src();
        req_len0 = 2; req_len1 = 4; start_req = 1'b1;
        cycle();
        for (int i = 0; i < 50 && m_acc != 3; i++) cycle();
        chk("t6_reach", m_acc, 3);
        chk("t6_buffered", m_occ, 1);
        clear_req = 1'b1;
        done_cyc = -1;
        repeat (4) cycle();
        chk("t6_no_done", done_cyc, -1);
        run_seq(1, 1, 30, -1, lat);
        chk("t6_restart_latency", lat, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
